// File: rtl/svm_stream_arbiter.sv
// svm_stream_arbiter
// Shares one fixed-latency SVM inference core between NUM_SRC AXI-Stream sample sources.
// Grants are round-robin and held for a whole packet. Each issued sample carries a
// {valid, src, last} tag through a shift pipe that matches the core latency. Results go
// into a credit-protected FIFO, so the core never stalls.
//
// Ports:
//   axi_clk, rst        clock, asynchronous active-high reset
//   s_axis_*            per-source sample streams (source i in slice i of tdata)
//   core_enable         core clock enable (0 in reset, 1 otherwise)
//   core_valid_in       sample issue strobe, core_features = granted sample
//   core_pred/valid_out core result, LATENCY cycles after issue
//   m_axis_*            results: {src_id[7:0], 8'h00, pred[15:0]}, tlast closes a packet
//   busy                grant held, tags in flight or FIFO non-empty
//   err_sync            sticky: core result strobe disagreed with the tag pipe
module svm_stream_arbiter #(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned NUM_FEATURES = 8,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned PRED_WIDTH   = 16,
    parameter int unsigned LATENCY      = 5,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                                    axi_clk,
    input  logic                                    rst,
    input  logic [NUM_SRC*NUM_FEATURES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]                      s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                      s_axis_tlast,
    output logic [NUM_SRC-1:0]                      s_axis_tready,
    output logic                                    core_enable,
    output logic                                    core_valid_in,
    output logic [NUM_FEATURES*DATA_WIDTH-1:0]      core_features,
    input  logic [PRED_WIDTH-1:0]                   core_pred,
    input  logic                                    core_valid_out,
    output logic [31:0]                             m_axis_tdata,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic                                    m_axis_tlast,
    output logic                                    busy,
    output logic                                    err_sync
);

    localparam int unsigned SW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned SAMPLE_W = NUM_FEATURES * DATA_WIDTH;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned EW       = 8 + 16 + 1;  // {src8, pred16, last}

    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [0:0] {StIdle = 1'b0, StLocked = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   grant_q, grant_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [LATENCY-1:0] tag_v_q;
    logic [LATENCY-1:0] tag_last_q;
    logic [SW-1:0]      tag_src_q [LATENCY];

    logic [EW-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            err_q;

    logic            handshake, have_credit, push, pop, push_ok, fifo_full;
    logic [31:0]     used;
    logic [SW-1:0]   pick;
    logic            found;
    int unsigned     arb_idx;
    logic [15:0]     pred_ext;
    logic [EW-1:0]   push_entry, rd_entry;

    // Credits are FIFO_DEPTH minus everything already promised a FIFO slot.
    assign used        = 32'(count_q) + 32'($countones(tag_v_q));
    assign have_credit = used < FIFO_DEPTH;
    assign handshake   = (state_q == StLocked) && have_credit && s_axis_tvalid[grant_q];

    // First requester strictly after rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        pick    = rr_ptr_q;
        arb_idx = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            arb_idx = (32'(rr_ptr_q) + k) % NUM_SRC;
            if (!found && s_axis_tvalid[arb_idx]) begin
                found = 1'b1;
                pick  = SW'(arb_idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        s_axis_tready = '0;
        unique case (state_q)
            StIdle: begin
                if (|s_axis_tvalid) begin
                    grant_d = pick;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                // Ready only looks at credits, never at tvalid.
                s_axis_tready[grant_q] = have_credit;
                if (handshake && s_axis_tlast[grant_q]) begin
                    rr_ptr_d = grant_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= SW'(NUM_SRC - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign core_enable   = ~rst;
    assign core_valid_in = handshake;
    assign core_features = handshake ? s_axis_tdata[32'(grant_q) * SAMPLE_W +: SAMPLE_W] : '0;

    // Tag pipe shifts every cycle so its last stage lines up with core_valid_out.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            tag_v_q    <= '0;
            tag_last_q <= '0;
            for (int k = 0; k < int'(LATENCY); k++) tag_src_q[k] <= '0;
        end else begin
            tag_v_q[0]    <= handshake;
            tag_src_q[0]  <= grant_q;
            tag_last_q[0] <= handshake & s_axis_tlast[grant_q];
            for (int k = 1; k < int'(LATENCY); k++) begin
                tag_v_q[k]    <= tag_v_q[k-1];
                tag_src_q[k]  <= tag_src_q[k-1];
                tag_last_q[k] <= tag_last_q[k-1];
            end
        end
    end

    always_comb begin
        pred_ext                 = '0;
        pred_ext[PRED_WIDTH-1:0] = core_pred;
    end

    // A result without a valid tag is still kept, attributed to src 0 with no last.
    assign push_entry = tag_v_q[LATENCY-1]
                      ? {8'(tag_src_q[LATENCY-1]), pred_ext, tag_last_q[LATENCY-1]}
                      : {8'h00, pred_ext, 1'b0};

    assign fifo_full = 32'(count_q) == FIFO_DEPTH;
    assign push      = core_valid_out;
    assign pop       = (count_q != '0) && m_axis_tready;
    // Only a misaligned core can reach a full FIFO; drop rather than corrupt.
    assign push_ok   = push && (!fifo_full || pop);

    always_ff @(posedge axi_clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push_ok && !pop)      count_q <= count_q + CNT_ONE;
            else if (!push_ok && pop) count_q <= count_q - CNT_ONE;
            if (core_valid_out != tag_v_q[LATENCY-1]) err_q <= 1'b1;
        end
    end

    assign rd_entry      = fifo_mem_q[rd_ptr_q];
    assign m_axis_tvalid = count_q != '0;
    assign m_axis_tdata  = m_axis_tvalid ? {rd_entry[EW-1 -: 8], 8'h00, rd_entry[16:1]} : '0;
    assign m_axis_tlast  = m_axis_tvalid & rd_entry[0];
    assign busy          = (state_q == StLocked) || (|tag_v_q) || (count_q != '0);
    assign err_sync      = err_q;

endmodule

// File: doc/svm_stream_arbiter.md
Name: svm_stream_arbiter

Overview:
- Shares one fixed-latency SVM inference core between NUM_SRC AXI-Stream sample sources.
- Uses packet-locked round-robin arbitration.
- Tags each issued sample with its source ID and last flag, carrying the tag through a shift pipeline aligned to the core latency.
- Collects results in a credit-protected output FIFO, so the core is never stalled and the DMA S2MM side can backpressure freely.

Parameters:
- NUM_SRC, 2: number of requesting sample streams (2..8).
- NUM_FEATURES, 8: features per sample.
- DATA_WIDTH, 16: bits per feature.
- PRED_WIDTH, 16: core prediction width.
- LATENCY, 5: core cycles from valid_in to valid_out (>=1).
- FIFO_DEPTH, 8: result FIFO entries (power of 2, >= LATENCY).

Ports:
- axi_clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- s_axis_tdata  in  NUM_SRC*NUM_FEATURES*DATA_WIDTH  per-source sample; source i occupies slice i.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- s_axis_tready  out  NUM_SRC  per-source ready.
- core_enable  out  1  core clock enable, tied to 1 after reset.
- core_valid_in  out  1  sample issue strobe.
- core_features  out  NUM_FEATURES*DATA_WIDTH  sample to core.
- core_pred  in  PRED_WIDTH  core prediction.
- core_valid_out  in  1  core result strobe.
- m_axis_tdata  out  32  {src_id[7:0], 8'h00, pred zero-extended to 16}.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  result closes a source packet.
- busy  out  1  grant held, or tags in flight, or FIFO non-empty.
- err_sync  out  1  sticky core/tag misalignment flag.

Behaviour:
- Reset (async, rst=1): state IDLE, rr_ptr=NUM_SRC-1, tag pipe cleared, FIFO empty, credits=FIFO_DEPTH. All outputs 0 except core_enable=0 during reset and 1 after.
- FSM IDLE: if any s_axis_tvalid bit is set, grant the first requesting index after rr_ptr (wrapping modulo NUM_SRC), then go to LOCKED. No transfer occurs in IDLE (one bubble cycle per packet).
- FSM LOCKED: s_axis_tready[g] = (credits>0); all other ready bits are 0.
  - Handshake on g: core_valid_in=1 and core_features = slice g, both combinational from the mux.
  - Handshake with tlast=1: rr_ptr<=g, go to IDLE.
  - tvalid low: stay in LOCKED (no timeout).
- Ready rule: s_axis_tready must not depend on s_axis_tvalid.
- Tag pipe: LATENCY stages of {v, src, last}. Stage 0 loads {handshake, g, tlast} every cycle; it shifts unconditionally.
- Result push: on core_valid_out=1, push {tag.src, core_pred, tag.last} from the final tag stage into the FIFO.
- err_sync: set if core_valid_out differs from the final-stage tag valid bit. Cleared only by reset. A result arriving with an invalid tag is still pushed, with src=0 and last=0.
- Credits: credits = FIFO_DEPTH - fifo_count - inflight, where inflight counts valid tag stages. Decrement on issue; increment on FIFO pop; simultaneous issue and pop leaves credits unchanged.
  - The invariant guarantees the FIFO never overflows.
  - Credits=0 forces all s_axis_tready low.
- FIFO: registered output. m_axis_tvalid = non-empty; pop on m_axis_tvalid & m_axis_tready; simultaneous push and pop is allowed at any occupancy, including full and empty. m_axis_tdata and m_axis_tlast hold stable while tvalid=1 and tready=0.
- Latency: input handshake at cycle T gives core_valid_out at T+LATENCY and m_axis_tvalid at T+LATENCY+1 when the FIFO was empty.
- Throughput: 1 sample/cycle within a packet.
- Reset mid-operation: in-flight tags and FIFO contents are discarded. The core must be reset by the same rst.

Test Plan:
- Single source 0, 4-beat packet, tlast on beat 3, m_axis_tready=1 → 4 results, each tdata[31:24]=0. First m_axis_tvalid 6 cycles after first handshake; m_axis_tlast only on the 4th.
- Both sources continuously valid, 2-beat packets → packets granted in order src0, src1, src0, src1, never interleaved. One idle bubble between packets.
- m_axis_tready=0, source streaming → exactly 8 handshakes accepted, then s_axis_tready=0. Raise tready → 8 results in order, no loss, streaming resumes.
- Core model valid_out delayed to LATENCY+1 → err_sync=1 on first result and stays 1 until rst.
- Assert rst asynchronously with 3 tags in flight and 2 FIFO entries → all outputs 0 immediately. After release, no stale results; credits=8.
- NUM_SRC=3: only src2 requests after rr_ptr=2 → wrap to src2 granted. Src0 and src2 both requesting after rr_ptr=0 → src2 granted first.
